// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode and
// FSM encodings plus small opcode-decode helpers.
package muldiv_iter_pkg;

    // Opcode encoding seen on the op input.
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    // Controller states; the raw encoding is also exported on dbg_state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } md_state_e;

    // Divide family (DIV/DIVU/REM/REMU) is selected by the top opcode bit.
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // Remainder ops take their result sign from the dividend only.
    function automatic logic md_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // Multiply ops that return the upper half of the product.
    function automatic logic md_is_mul_hi(input logic [2:0] op);
        return ~op[2] & (op[1:0] != 2'b00);
    endfunction

    // Operand A is interpreted as signed.
    function automatic logic md_is_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV)  || (op == MD_REM);
    endfunction

    // Operand B is interpreted as signed.
    function automatic logic md_is_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
// The datapath is a {hi, lo} register pair plus an operand register:
//   multiply: hi = partial product, lo = multiplier (consumed LSB first),
//             opb = multiplicand magnitude.
//   divide:   hi = partial remainder (WIDTH+1 bits), lo = dividend shifting
//             out MSB first while quotient bits shift in, opb = divisor.
import muldiv_iter_pkg::*;

module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH:0]   hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH:0]   hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] mul_addend;
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shifted;
    logic [WIDTH:0] div_trial;

    // Shift-add and trial-subtract are both evaluated; is_div_i selects one.
    always_comb begin
        // Multiply: conditionally add the multiplicand, then shift the whole
        // accumulator right by one. hi stays below 2^WIDTH before the add, so
        // the WIDTH+1-bit sum never overflows.
        mul_addend = lo_i[0] ? {1'b0, opb_i} : '0;
        mul_sum    = hi_i + mul_addend;

        // Divide: bring the next dividend bit into the remainder and try to
        // subtract the divisor. A set MSB on the trial means it went negative,
        // so the shifted remainder is kept (restoring step).
        div_shifted = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
        div_trial   = div_shifted - {1'b0, opb_i};

        hi_o = {1'b0, mul_sum[WIDTH:1]};
        lo_o = {mul_sum[0], lo_i[WIDTH-1:1]};
        if (is_div_i) begin
            if (!div_trial[WIDTH]) begin
                hi_o = div_trial;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = div_shifted;
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the execute stage. Operands are reduced
// to magnitudes on acceptance, a radix-2 step runs once per cycle, and the
// sign is restored when the result is selected. Latency is fixed for every
// opcode: WIDTH active steps plus one terminal RUN cycle, then one FIN cycle
// in which done pulses.
//
// Handshake: start is sampled only in IDLE and is ignored whenever the unit is
// busy (RUN or FIN); flush kills the operation from any state and takes
// priority over start; done is high for exactly the FIN cycle, during which y
// and div_by_zero are already valid and then held until the next FIN.
import muldiv_iter_pkg::*;

module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             dbz_out_q, dbz_out_d;

    // Operand conditioning at acceptance time.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Single-iteration datapath outputs.
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;

    // Result formation from the finished accumulator.
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, result;

    muldiv_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div_i (md_is_div(op_q)),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .opb_i    (opb_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // Magnitudes of the incoming operands; the unsigned value of |MIN_INT| is
    // 2^(WIDTH-1), which still fits in WIDTH bits, so no magnitude bit is lost.
    always_comb begin
        a_neg = md_is_signed_a(op) & a[WIDTH-1];
        b_neg = md_is_signed_b(op) & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // Sign fix and result select. Division by zero naturally leaves the
    // remainder equal to |a| (which the sign fix turns back into a), but the
    // quotient must be forced to all ones regardless of the dividend sign.
    always_comb begin
        prod_raw = {acc_hi_q[WIDTH-1:0], acc_lo_q};
        prod_fix = sign_q ? (~prod_raw + 1'b1) : prod_raw;
        quot_fix = sign_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_fix  = sign_q ? (~acc_hi_q[WIDTH-1:0] + 1'b1) : acc_hi_q[WIDTH-1:0];

        if (md_is_rem(op_q)) begin
            result = rem_fix;
        end else if (md_is_div(op_q)) begin
            result = dbz_q ? '1 : quot_fix;
        end else if (md_is_mul_hi(op_q)) begin
            result = prod_fix[2*WIDTH-1:WIDTH];
        end else begin
            result = prod_fix[WIDTH-1:0];
        end
    end

    // Next-state, datapath and result-register update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sign_d    = sign_q;
        dbz_d     = dbz_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        y_d       = y_q;
        dbz_out_d = dbz_out_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    state_d  = ST_RUN;
                    cnt_d    = CNT_W'(WIDTH);
                    op_d     = op;
                    sign_d   = md_is_rem(op) ? a_neg : (a_neg ^ b_neg);
                    dbz_d    = md_is_div(op) && (b == '0);
                    acc_hi_d = '0;
                    if (md_is_div(op)) begin
                        acc_lo_d = a_mag;
                        opb_d    = b_mag;
                    end else begin
                        acc_lo_d = b_mag;
                        opb_d    = a_mag;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    // Terminal RUN cycle: capture the result so it is valid
                    // throughout FIN alongside done.
                    state_d   = ST_FIN;
                    y_d       = result;
                    dbz_out_d = dbz_q;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            sign_q    <= 1'b0;
            dbz_q     <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            y_q       <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sign_q    <= sign_d;
            dbz_q     <= dbz_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            y_q       <= y_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign y           = y_q;
    assign div_by_zero = dbz_out_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at WIDTH=32: hand-computed arithmetic
// vectors, fixed-latency checks, flush/start corner cases and async reset.
module tb_muldiv_iter;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         flush;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int n_vec;
    int n_err;

    muldiv_iter #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .flush       (flush),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .y           (y),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one op, scramble the operand inputs after acceptance, optionally
    // pulse start mid-run, then check latency, busy, result and hold.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] ey, input logic edbz,
                          input bit poke);
        int  edges;
        bit  seen;
        bit  busy_ok;
        @(negedge clk);
        op = o; a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        edges = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && edges < LAT + 8) begin
            if (!busy) busy_ok = 1'b0;
            if (poke && edges == 5) start = 1'b1;
            if (poke && edges == 6) start = 1'b0;
            @(posedge clk); #1;
            edges++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(edges), 32'(LAT));
        chk({tag, " busy_run"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, " y"}, y, ey);
        chk({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, " y_hold"}, y, ey);
        chk({tag, " idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int dcount;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst y", y, 32'd0);
        chk("rst dbz", {31'b0, div_by_zero}, 32'd0);
        chk("rst state", {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic vectors (op, a, b, expected y, expected div_by_zero)
        run_op("mul 3*4",      3'b000, 32'd3,        32'd4,        32'h0000000C, 1'b0, 1'b0);
        run_op("mul -3*4",     3'b000, 32'hFFFFFFFD, 32'd4,        32'hFFFFFFF4, 1'b0, 1'b0);
        run_op("mul lo min",   3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
        run_op("mulhu max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("mulh min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0);
        run_op("mulh -1*-1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
        run_op("mulhsu -1*2",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("div -7/2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("rem -7/2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("div 7/-2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("rem 7/-2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        run_op("divu 10/3",    3'b101, 32'd10,       32'd3,        32'd3,        1'b0, 1'b1);
        run_op("remu 10/3",    3'b111, 32'd10,       32'd3,        32'd1,        1'b0, 1'b0);
        run_op("div 5/0",      3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("rem 5/0",      3'b110, 32'd5,        32'd0,        32'd5,        1'b1, 1'b0);
        run_op("div -5/0",     3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("rem -5/0",     3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1, 1'b0);
        run_op("divu max/0",   3'b101, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("div min/-1",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1);
        run_op("rem min/-1",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);

        // Flush at RUN cycle 10: back to IDLE, no done, y keeps last result
        @(negedge clk);
        op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("flush pre state", {30'b0, dbg_state}, 32'd1);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", {31'b0, busy}, 32'd0);
        chk("flush state", {30'b0, dbg_state}, 32'd0);
        dcount = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("flush no done", 32'(dcount), 32'd0);
        chk("flush y hold", y, 32'h00000000);

        // flush and start together in IDLE: not accepted
        @(negedge clk);
        op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush+start busy", {31'b0, busy}, 32'd0);

        // start held during FIN is ignored; unit returns to IDLE
        @(negedge clk);
        op = 3'b000; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0;
        while (!done && dcount < LAT + 8) begin
            @(posedge clk); #1;
            dcount++;
        end
        chk("fin latency", 32'(dcount), 32'(LAT));
        chk("fin y", y, 32'd6);
        op = 3'b000; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("fin start ignored", {31'b0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("fin still idle", {31'b0, busy}, 32'd0);
        chk("fin y kept", y, 32'd6);

        // Async reset mid-RUN clears outputs without a clock edge
        @(negedge clk);
        op = 3'b001; a = 32'h12345678; b = 32'h9ABCDEF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy", {31'b0, busy}, 32'd0);
        chk("arst done", {31'b0, done}, 32'd0);
        chk("arst y", y, 32'd0);
        chk("arst state", {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal operation resumes after reset
        run_op("post-rst mul", 3'b000, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
